// File: rtl/spi_slave_periph_pkg.sv
// Shared definitions for the SPI target peripheral: register indices, STATUS/CTRL bit
// positions and FSM state encoding.
package spi_slave_periph_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_RX     = 2'd2,
        REG_TX     = 2'd3
    } reg_idx_e;

    localparam int ST_RXF  = 0;
    localparam int ST_TXE  = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_BUSY = 3;
    localparam int ST_ABT  = 4;
    localparam int ST_UND  = 5;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 7;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/spi_slave_periph_if.sv
// CPU peripheral bus between firmware (master) and the SPI target register file (slave).
interface spi_slave_periph_if;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       wr_en;
    logic       rd_en;

    modport master (output addr, output din, output wr_en, output rd_en, input dout);
    modport slave  (input addr, input din, input wr_en, input rd_en, output dout);
endinterface

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for an asynchronous pin with single-cycle rise/fall pulses
// taken from the synchronized level.
module spi_slave_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);
    logic meta_p0, sync_p1, prev_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
            prev_p2 <= RESET_VAL;
        end else begin
            meta_p0 <= async_in;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign sync_out = sync_p1;
    assign rise     = sync_p1 & ~prev_p2;
    assign fall     = ~sync_p1 & prev_p2;
endmodule

// File: rtl/spi_slave_periph.sv
// SPI mode-0 target peripheral with a 4-register CPU interface; pins are oversampled on clk.
// Optional interrupt output and CTRL.IE are built when SPI_SLAVE_IRQ_EN is defined.
module spi_slave_periph
    import spi_slave_periph_pkg::*;
#(
    parameter int         ADDR_LSB          = 0,
    parameter int         OPT_MEM_ADDR_BITS = 1,
    parameter logic [7:0] DUMMY_BYTE        = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    spi_slave_periph_if.slave  bus,
    input  logic               sclk,
    input  logic               mosi,
    input  logic               ss_n,
    output logic               miso,
    output logic               miso_oe
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic               irq
`endif
);
    localparam int IDX_W = OPT_MEM_ADDR_BITS + 1;

    logic [IDX_W-1:0] idx;
    logic             unused_addr;
    state_e           state;
    logic             en, rxf, txe, ovr, busy, abt, und, ie;
    logic [7:0]       rx_data, tx_data, shifter, load_byte;
    logic [2:0]       bitcnt;
    logic             sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
    logic             unused_sclk_s, unused_ss_s, unused_mosi_rise, unused_mosi_fall;
    logic             wr_ctrl, wr_status, wr_tx, rd_rx;
    logic             leave, enter, reload, byte_done, abort;

    spi_slave_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .async_in(sclk),
        .sync_out(unused_sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_slave_sync #(.RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .async_in(ss_n),
        .sync_out(unused_ss_s), .rise(ss_rise), .fall(ss_fall));
    spi_slave_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .async_in(mosi),
        .sync_out(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

    assign idx         = bus.addr[ADDR_LSB +: IDX_W];
    assign unused_addr = ^bus.addr;

    assign wr_ctrl   = bus.wr_en && (idx == IDX_W'(REG_CTRL));
    assign wr_status = bus.wr_en && (idx == IDX_W'(REG_STATUS));
    assign wr_tx     = bus.wr_en && (idx == IDX_W'(REG_TX));
    assign rd_rx     = bus.rd_en && (idx == IDX_W'(REG_RX));

    // Deselect and disable both end a transfer; mid-byte either one counts as an abort.
    assign leave     = ss_rise || !en;
    assign enter     = (state == S_IDLE) && en && ss_fall;
    assign byte_done = (state == S_SHIFT) && !leave && sclk_rise && (bitcnt == 3'd7);
    assign abort     = (state == S_SHIFT) && leave && (bitcnt != 3'd0);
    assign reload    = enter || ((state == S_SHIFT) && !leave && sclk_fall && (bitcnt == 3'd0));
    assign load_byte = txe ? DUMMY_BYTE : tx_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            en      <= 1'b0;
            rxf     <= 1'b0;
            txe     <= 1'b1;
            ovr     <= 1'b0;
            busy    <= 1'b0;
            abt     <= 1'b0;
            und     <= 1'b0;
            rx_data <= '0;
            tx_data <= '0;
            shifter <= '0;
            bitcnt  <= '0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    bitcnt  <= '0;
                    if (enter) begin
                        state   <= S_SHIFT;
                        miso_oe <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (leave) begin
                        state   <= S_IDLE;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        bitcnt  <= '0;
                        miso    <= 1'b0;
                    end else if (sclk_rise) begin
                        shifter <= {shifter[6:0], mosi_s};
                        bitcnt  <= bitcnt + 3'd1;
                    end else if (sclk_fall && (bitcnt != 3'd0)) begin
                        miso <= shifter[7];
                    end
                end
            endcase

            // Load sees the pre-write TXE; a same-cycle TX write below then re-arms TXE=0.
            if (reload) begin
                shifter <= load_byte;
                miso    <= load_byte[7];
                if (!txe) txe <= 1'b1;
                else      und <= 1'b1;
            end

            if (wr_ctrl) en <= bus.din[CTRL_EN];
            if (wr_status) begin
                if (bus.din[ST_OVR]) ovr <= 1'b0;
                if (bus.din[ST_ABT]) abt <= 1'b0;
                if (bus.din[ST_UND]) und <= 1'b0;
            end
            if (rd_rx) rxf <= 1'b0;

            // Flag sets come after clears so a same-cycle set wins.
            if (byte_done) begin
                rx_data <= {shifter[6:0], mosi_s};
                rxf     <= 1'b1;
                if (rxf && !rd_rx) ovr <= 1'b1;
            end
            if (abort) abt <= 1'b1;
            if (wr_tx) begin
                tx_data <= bus.din;
                txe     <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr_ctrl) ie <= bus.din[CTRL_IE];
            irq <= ie & (rxf | ovr | abt);
        end
    end
`else
    assign ie = 1'b0;
`endif

    always_comb begin
        bus.dout = '0;
        case (idx)
            IDX_W'(REG_CTRL): begin
                bus.dout[CTRL_EN] = en;
                bus.dout[CTRL_IE] = ie;
            end
            IDX_W'(REG_STATUS): bus.dout[5:0] = {und, abt, busy, ovr, txe, rxf};
            IDX_W'(REG_RX):     bus.dout = rx_data;
            default:            bus.dout = '0;
        endcase
    end
endmodule

// File: tb/tb_spi_slave_periph.sv
// Scoreboard bench for spi_slave_periph: a transaction-level register/flag model predicts
// CPU reads and miso bytes; monitors compare them as the DUT presents them.
module tb_spi_slave_periph;
    import spi_slave_periph_pkg::*;

    logic clk = 1'b0;
    logic reset, sclk, mosi, ss_n;
    logic miso, miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
    logic irq;
`endif

    spi_slave_periph_if bus ();

    spi_slave_periph dut (
        .clk(clk), .reset(reset), .bus(bus),
        .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .miso_oe(miso_oe)
`ifdef SPI_SLAVE_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    bit         m_en, m_ie, m_rxf, m_txe, m_ovr, m_abt, m_und;
    logic [7:0] m_rx, m_tx;

    string      exp_rd_name[$];
    logic [7:0] exp_rd_val[$];
    logic [7:0] exp_miso_q[$];
    logic [7:0] got_miso_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_rxf = 0; m_txe = 1;
        m_ovr = 0; m_abt = 0; m_und = 0; m_rx = 8'h00; m_tx = 8'h00;
    endtask

    function automatic logic [7:0] model_read(input reg_idx_e idx);
        case (idx)
            REG_CTRL:   return {m_ie, 6'b0, m_en};
            REG_STATUS: return {2'b00, m_und, m_abt, 1'b0, m_ovr, m_txe, m_rxf};
            REG_RX:     return m_rx;
            default:    return 8'h00;
        endcase
    endfunction

    // A byte is placed in the shifter at select and after every completed byte.
    task automatic model_load(input bit push);
        logic [7:0] v;
        if (!m_txe) begin v = m_tx; m_txe = 1; end
        else begin v = 8'hFF; m_und = 1; end
        if (push) exp_miso_q.push_back(v);
    endtask

    task automatic bus_write(input reg_idx_e idx, input logic [7:0] v);
        bus.addr = {6'($urandom), 2'(idx)};
        bus.din  = v;
        bus.wr_en = 1'b1;
        cyc(1);
        bus.wr_en = 1'b0;
        case (idx)
            REG_CTRL: begin
                m_en = v[0];
`ifdef SPI_SLAVE_IRQ_EN
                m_ie = v[7];
`endif
            end
            REG_STATUS: begin
                if (v[2]) m_ovr = 0;
                if (v[4]) m_abt = 0;
                if (v[5]) m_und = 0;
            end
            REG_TX: begin m_tx = v; m_txe = 0; end
            default: ;
        endcase
    endtask

    task automatic bus_read(input reg_idx_e idx, input string name);
        exp_rd_name.push_back(name);
        exp_rd_val.push_back(model_read(idx));
        bus.addr = {6'($urandom), 2'(idx)};
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
        if (idx == REG_RX) m_rxf = 0;
    endtask

    // Master at clk/8: nbytes full bytes, then optionally abort_bits of a partial byte.
    task automatic spi_session(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                               input int abort_bits, input bit rd_hook);
        bit         act;
        int         total, nbits;
        logic [7:0] cur, got;
        act   = m_en;
        total = nbytes + ((abort_bits > 0) ? 1 : 0);
        if (act) model_load(nbytes > 0);
        ss_n = 1'b0;
        cyc(8);
        for (int i = 0; i < total; i++) begin
            nbits = (i < nbytes) ? 8 : abort_bits;
            cur   = (i == 0) ? b0 : b1;
            got   = 8'h00;
            for (int j = 0; j < nbits; j++) begin
                mosi = cur[7-j];
                cyc(4);
                sclk = 1'b1;
                got  = {got[6:0], miso};
                if (rd_hook && (i == nbytes - 1) && (j == 7)) begin
                    cyc(2);
                    exp_rd_name.push_back("rx_same_cycle");
                    exp_rd_val.push_back(m_rx);
                    bus.addr  = {6'($urandom), 2'(REG_RX)};
                    bus.rd_en = 1'b1;
                    cyc(1);
                    bus.rd_en = 1'b0;
                    cyc(1);
                end else if (j == 3) begin
                    cyc(2);
                    check("miso_oe_selected", int'(miso_oe), int'(act));
                    cyc(2);
                end else begin
                    cyc(4);
                end
                sclk = 1'b0;
            end
            if ((i < nbytes) && act) begin
                got_miso_q.push_back(got);
                if (m_rxf && !(rd_hook && (i == nbytes - 1))) m_ovr = 1;
                m_rx  = cur;
                m_rxf = 1;
                model_load(i + 1 < nbytes);
            end
        end
        cyc(4);
        ss_n = 1'b1;
        if (act && (abort_bits > 0)) m_abt = 1;
        cyc(8);
    endtask

    always @(negedge clk) begin
        if (bus.rd_en === 1'b1) begin
            if (exp_rd_val.size() == 0) check("read_unexpected", 1, 0);
            else check(exp_rd_name.pop_front(), int'(bus.dout), int'(exp_rd_val.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (got_miso_q.size() > 0) begin
            if (exp_miso_q.size() == 0) check("miso_unexpected", int'(got_miso_q.pop_front()), -1);
            else check("miso_byte", int'(got_miso_q.pop_front()), int'(exp_miso_q.pop_front()));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int nb, ab;
        bus.addr = '0; bus.din = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        model_reset();
        cyc(2);
        check("reset_miso", int'(miso), 0);
        check("reset_miso_oe", int'(miso_oe), 0);
        bus_read(REG_CTRL, "reset_ctrl");
        bus_read(REG_STATUS, "reset_status");
        bus_read(REG_RX, "reset_rx");
        bus_read(REG_TX, "reset_tx");

        // Basic exchange: TX 0xA5 out, 0x3C in.
        bus_write(REG_CTRL, 8'h01);
        bus_write(REG_TX, 8'hA5);
        spi_session(1, 8'h3C, 8'h00, 0, 0);
        bus_read(REG_STATUS, "t1_status");
        bus_read(REG_RX, "t1_rx");

        // Two bytes, no RX read, no TX load: overrun and underrun.
        spi_session(2, 8'h11, 8'h22, 0, 0);
        bus_read(REG_STATUS, "t2_status");
        bus_read(REG_RX, "t2_rx");

        // Abort after 5 bits, then a full byte.
        bus_write(REG_STATUS, 8'h34);
        spi_session(0, 8'h5A, 8'h00, 5, 0);
        bus_read(REG_STATUS, "t3_status_abt");
        spi_session(1, 8'h81, 8'h00, 0, 0);
        bus_read(REG_STATUS, "t3_status");

        // CPU RX read in the same cycle the byte completes (RXF already set).
        bus_write(REG_STATUS, 8'h34);
        spi_session(1, 8'hC3, 8'h00, 0, 1);
        bus_read(REG_STATUS, "t4_status");
        bus_read(REG_RX, "t4_rx");

        // W1C, then disabled: no activity.
        bus_write(REG_STATUS, 8'h34);
        bus_read(REG_STATUS, "t5_w1c_status");
        bus_write(REG_CTRL, 8'h00);
        spi_session(1, 8'h77, 8'h00, 0, 0);
        bus_read(REG_STATUS, "t5_dis_status");
        bus_read(REG_CTRL, "t5_ctrl");
        bus_write(REG_CTRL, 8'h01);

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(1, 0) == 1) bus_write(REG_TX, 8'($urandom));
            if ($urandom_range(3, 0) == 0) bus_write(REG_STATUS, 8'($urandom));
            nb = $urandom_range(2, 0);
            ab = ($urandom_range(2, 0) == 0) ? $urandom_range(7, 1) : 0;
            if ((nb == 0) && (ab == 0)) nb = 1;
            spi_session(nb, 8'($urandom), 8'($urandom), ab, 0);
            bus_read(REG_STATUS, "rand_status");
            if ($urandom_range(1, 0) == 1) bus_read(REG_RX, "rand_rx");
            if ($urandom_range(3, 0) == 0) bus_read(REG_TX, "rand_tx");
        end

        // Reset while selected.
        bus_write(REG_CTRL, 8'h01);
        bus_write(REG_TX, 8'h96);
        ss_n = 1'b0;
        cyc(8);
        check("oe_before_reset", int'(miso_oe), 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        model_reset();
        check("oe_after_reset", int'(miso_oe), 0);
        check("miso_after_reset", int'(miso), 0);
        ss_n = 1'b1;
        cyc(6);
        bus_read(REG_STATUS, "post_reset_status");
        bus_read(REG_CTRL, "post_reset_ctrl");

`ifdef SPI_SLAVE_IRQ_EN
        bus_write(REG_CTRL, 8'h81);
        cyc(2);
        check("irq_idle", int'(irq), 0);
        spi_session(1, 8'h42, 8'h00, 0, 0);
        check("irq_after_rx", int'(irq), 1);
        bus_read(REG_RX, "irq_rx");
        cyc(1);
        check("irq_cleared", int'(irq), 0);
`endif

        cyc(5);
        check("reads_outstanding", exp_rd_val.size(), 0);
        check("miso_outstanding", exp_miso_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
